// File: rtl/led_mode_ctrl.sv
// Four-channel LED driver: OFF/ON/BLINK/BREATHE modes with PWM dimming,
// a shared animation tick and a per-channel activity flash override.
module led_mode_ctrl #(
    parameter int TICK_DIV    = 1024,
    parameter int BLINK_TICKS = 128,
    parameter int FLASH_TICKS = 16
) (
    input  logic       i_clk,
    input  logic       i_rst,
    input  logic       i_wr_en,
    input  logic [1:0] i_wr_ch,
    input  logic [1:0] i_wr_mode,
    input  logic [7:0] i_wr_bright,
    input  logic [3:0] i_evt,
    output logic [3:0] o_led,
    output logic       o_tick
);

    localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam int BW = (BLINK_TICKS > 1) ? $clog2(BLINK_TICKS) : 1;
    localparam int FW = (FLASH_TICKS > 0) ? $clog2(FLASH_TICKS + 1) : 1;

    localparam logic [PW-1:0] PRESC_MAX  = PW'(TICK_DIV - 1);
    localparam logic [BW-1:0] BLINK_MAX  = BW'(BLINK_TICKS - 1);
    localparam logic [FW-1:0] FLASH_LOAD = FW'(FLASH_TICKS);

    typedef enum logic [1:0] {
        M_OFF     = 2'b00,
        M_ON      = 2'b01,
        M_BLINK   = 2'b10,
        M_BREATHE = 2'b11
    } mode_e;

    logic [7:0]    pwm_q, pwm_d;
    logic [PW-1:0] presc_q, presc_d;
    logic          tick_q, tick_d;
    logic [7:0]    level_q, level_d;
    logic          dir_up_q, dir_up_d;
    logic [BW-1:0] blink_cnt_q, blink_cnt_d;
    logic          blink_ph_q, blink_ph_d;
    mode_e         mode_q [4];
    mode_e         mode_d [4];
    logic [7:0]    bright_q [4];
    logic [7:0]    bright_d [4];
    logic [FW-1:0] flash_q [4];
    logic [FW-1:0] flash_d [4];
    logic [3:0]    led_q, led_d;
    logic [15:0]   prod [4];
    logic [7:0]    duty [4];

    always_comb begin
        pwm_d       = pwm_q + 8'd1;
        tick_d      = (presc_q == PRESC_MAX);
        presc_d     = tick_d ? '0 : presc_q + PW'(1);
        level_d     = level_q;
        dir_up_d    = dir_up_q;
        blink_cnt_d = blink_cnt_q;
        blink_ph_d  = blink_ph_q;

        // Triangle wave: turns around on reaching 255 or 0, never holds.
        if (tick_q) begin
            if (dir_up_q) begin
                level_d = level_q + 8'd1;
                if (level_q == 8'd254) dir_up_d = 1'b0;
            end else begin
                level_d = level_q - 8'd1;
                if (level_q == 8'd1) dir_up_d = 1'b1;
            end
            if (blink_cnt_q == BLINK_MAX) begin
                blink_cnt_d = '0;
                blink_ph_d  = ~blink_ph_q;
            end else begin
                blink_cnt_d = blink_cnt_q + BW'(1);
            end
        end

        for (int n = 0; n < 4; n++) begin
            mode_d[n]   = mode_q[n];
            bright_d[n] = bright_q[n];
            flash_d[n]  = flash_q[n];
            if (i_evt[n]) begin
                flash_d[n] = FLASH_LOAD;
            end else if (tick_q && flash_q[n] != '0) begin
                flash_d[n] = flash_q[n] - FW'(1);
            end

            prod[n] = 16'(level_q) * 16'(bright_q[n]);
            duty[n] = '0;
            unique case (mode_q[n])
                M_OFF:     duty[n] = '0;
                M_ON:      duty[n] = bright_q[n];
                M_BLINK:   duty[n] = blink_ph_q ? bright_q[n] : 8'd0;
                M_BREATHE: duty[n] = prod[n][15:8];
            endcase
            if (flash_q[n] != '0) duty[n] = 8'hFF;
            led_d[n] = ~(pwm_q < duty[n]);
        end

        if (i_wr_en) begin
            mode_d[i_wr_ch]   = mode_e'(i_wr_mode);
            bright_d[i_wr_ch] = i_wr_bright;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            pwm_q       <= '0;
            presc_q     <= '0;
            tick_q      <= 1'b0;
            level_q     <= '0;
            dir_up_q    <= 1'b1;
            blink_cnt_q <= '0;
            blink_ph_q  <= 1'b0;
            led_q       <= 4'b1111;
            for (int n = 0; n < 4; n++) begin
                mode_q[n]   <= M_OFF;
                bright_q[n] <= 8'hFF;
                flash_q[n]  <= '0;
            end
        end else begin
            pwm_q       <= pwm_d;
            presc_q     <= presc_d;
            tick_q      <= tick_d;
            level_q     <= level_d;
            dir_up_q    <= dir_up_d;
            blink_cnt_q <= blink_cnt_d;
            blink_ph_q  <= blink_ph_d;
            led_q       <= led_d;
            for (int n = 0; n < 4; n++) begin
                mode_q[n]   <= mode_d[n];
                bright_q[n] <= bright_d[n];
                flash_q[n]  <= flash_d[n];
            end
        end
    end

    assign o_led  = led_q;
    assign o_tick = tick_q;

endmodule

// File: tb/tb_led_mode_ctrl.sv
// Directed bench for led_mode_ctrl with TICK_DIV=4, BLINK_TICKS=2,
// FLASH_TICKS=3; expectations are closed-form in edges since reset.
module tb_led_mode_ctrl;

    logic       clk = 1'b0;
    logic       rst;
    logic       wr_en;
    logic [1:0] wr_ch;
    logic [1:0] wr_mode;
    logic [7:0] wr_br;
    logic [3:0] evt;
    logic [3:0] led;
    logic       tick;

    int k;
    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    led_mode_ctrl #(
        .TICK_DIV(4),
        .BLINK_TICKS(2),
        .FLASH_TICKS(3)
    ) dut (
        .i_clk(clk),
        .i_rst(rst),
        .i_wr_en(wr_en),
        .i_wr_ch(wr_ch),
        .i_wr_mode(wr_mode),
        .i_wr_bright(wr_br),
        .i_evt(evt),
        .o_led(led),
        .o_tick(tick)
    );

    // k = number of edges since the last edge that sampled reset
    always @(posedge clk) k <= rst ? 0 : k + 1;

    typedef struct {
        logic [1:0] ch;
        logic [1:0] mode;
        logic [7:0] br;
        int         lit;
    } vec_t;

    vec_t vecs [6];

    task automatic step(input int n = 1);
        repeat (n) @(negedge clk);
    endtask

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic do_reset(input int n);
        rst = 1'b1; wr_en = 1'b0; evt = '0;
        step(n);
        rst = 1'b0;
    endtask

    task automatic wr(input logic [1:0] ch, input logic [1:0] md,
                      input logic [7:0] br);
        wr_en = 1'b1; wr_ch = ch; wr_mode = md; wr_br = br;
        step(1);
        wr_en = 1'b0;
    endtask

    // ticks applied to animation state by the end of edge j
    function automatic int tcnt(input int j);
        return (j >= 1) ? (j - 1) / 4 : 0;
    endfunction

    function automatic int lvl(input int t);
        int m;
        m = t % 510;
        return (m <= 255) ? m : 510 - m;
    endfunction

    function automatic bit tick_edge(input int e);
        return (e >= 5) && ((e - 1) % 4 == 0);
    endfunction

    function automatic int fl_at(input int j);
        int fl;
        fl = 0;
        for (int e = 1; e <= j; e++) begin
            if (e == 10 || e == 19 || e == 41) fl = 3;
            else if (tick_edge(e) && fl > 0) fl = fl - 1;
        end
        return fl;
    endfunction

    initial begin
        int errs, errs2, first, cnt_a, cnt_b;
        int cnt [4];
        logic [3:0] exp_led;
        logic [7:0] d0, d3;
        wr_en = 0; wr_ch = 0; wr_mode = 0; wr_br = 0; evt = 0; rst = 1;

        vecs[0] = '{2'd0, 2'b01, 8'h40, 64};
        vecs[1] = '{2'd1, 2'b01, 8'h00, 0};
        vecs[2] = '{2'd2, 2'b01, 8'hFF, 255};
        vecs[3] = '{2'd3, 2'b00, 8'h80, 0};
        vecs[4] = '{2'd1, 2'b01, 8'h01, 1};
        vecs[5] = '{2'd3, 2'b01, 8'h80, 128};

        // reset and tick cadence
        step(1);
        check("rst_led", 32'(led), 32'hF);
        check("rst_tick", 32'(tick), 0);
        step(2);
        rst = 1'b0;
        errs = 0; first = -1;
        for (int i = 0; i < 20; i++) begin
            step(1);
            if (tick !== ((k % 4 == 0) ? 1'b1 : 1'b0)) errs++;
            if (tick === 1'b1 && first < 0) first = k;
        end
        check("tick_cadence", 32'(errs), 0);
        check("tick_first", 32'(first), 4);

        // static ON/OFF duty table
        for (int v = 0; v < 6; v++) begin
            do_reset(1);
            wr(vecs[v].ch, vecs[v].mode, vecs[v].br);
            step(1);
            for (int b = 0; b < 4; b++) cnt[b] = 0;
            for (int i = 0; i < 256; i++) begin
                step(1);
                for (int b = 0; b < 4; b++) if (led[b] === 1'b0) cnt[b]++;
            end
            errs = 0;
            for (int b = 0; b < 4; b++)
                if (b != int'(vecs[v].ch)) errs += cnt[b];
            check($sformatf("tbl%0d_lit", v), 32'(cnt[vecs[v].ch]),
                  32'(vecs[v].lit));
            check($sformatf("tbl%0d_others", v), 32'(errs), 0);
        end

        // blink: dark 8 cycles, lit 8 cycles, repeating
        do_reset(1);
        wr(2'd1, 2'b10, 8'hFF);
        errs = 0; cnt_a = 0; cnt_b = 0;
        for (int i = 0; i < 80; i++) begin
            step(1);
            exp_led = 4'b1111;
            if (((tcnt(k - 1) / 2) % 2 == 1) && ((k - 1) % 256 < 255))
                exp_led[1] = 1'b0;
            if (led !== exp_led) errs++;
            if (k >= 2 && k <= 9 && led[1] === 1'b0) cnt_a++;
            if (k >= 10 && k <= 17 && led[1] === 1'b0) cnt_b++;
        end
        check("blink_trace", 32'(errs), 0);
        check("blink_dark_win", 32'(cnt_a), 0);
        check("blink_lit_win", 32'(cnt_b), 8);

        // flash with retrigger, plus a load landing on a tick edge
        do_reset(1);
        errs = 0; cnt_a = 0;
        for (int i = 0; i < 70; i++) begin
            step(1);
            exp_led = 4'b1111;
            if (fl_at(k - 1) > 0 && ((k - 1) % 256 < 255)) exp_led[2] = 1'b0;
            if (led !== exp_led) errs++;
            if (led[2] === 1'b0) cnt_a++;
            evt = (k + 1 == 10 || k + 1 == 19 || k + 1 == 41) ? 4'b0100 : 4'b0000;
        end
        evt = '0;
        check("flash_trace", 32'(errs), 0);
        check("flash_lit_total", 32'(cnt_a), 31);

        // breathe on ch3 (0x80) and ch0 (0xFF) across both turnarounds
        do_reset(1);
        wr(2'd3, 2'b11, 8'h80);
        wr(2'd0, 2'b11, 8'hFF);
        errs = 0; errs2 = 0;
        for (int i = 0; i < 2200; i++) begin
            step(1);
            d3 = 8'((lvl(tcnt(k - 1)) * 128) >> 8);
            d0 = 8'((lvl(tcnt(k - 1)) * 255) >> 8);
            exp_led = 4'b1111;
            if ((k - 1) % 256 < int'(d0)) exp_led[0] = 1'b0;
            if ((k - 1) % 256 < int'(d3)) exp_led[3] = 1'b0;
            if (led !== exp_led) begin
                if ((tcnt(k - 1) % 510) < 255) errs++;
                else errs2++;
            end
        end
        check("breathe_rising", 32'(errs), 0);
        check("breathe_falling", 32'(errs2), 0);

        // reset mid-flash with writes and events held during reset
        do_reset(1);
        wr(2'd1, 2'b01, 8'hFF);
        evt = 4'b0001;
        step(1);
        evt = '0;
        step(3);
        rst = 1'b1; evt = 4'hF;
        wr_en = 1'b1; wr_ch = 2'd2; wr_mode = 2'b01; wr_br = 8'hFF;
        step(2);
        check("midrst_led", 32'(led), 32'hF);
        rst = 1'b0; evt = '0; wr_en = 1'b0;
        step(1);
        check("midrst_release", 32'(led), 32'hF);
        errs = 0;
        for (int i = 0; i < 300; i++) begin
            step(1);
            if (led !== 4'hF) errs++;
        end
        check("midrst_all_off", 32'(errs), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
